// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I-subset pipeline decode stage.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    // Contents of the ID/EX pipeline register; all-zero is a bubble.
    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   imm_ext;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        result_src_t       result_src;
        alu_ctrl_t         alu_ctrl;
    } idex_t;

    // True for the funct3 values the ALU subset implements.
    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    // Map funct3 to an ALU operation; sub is only chosen when the caller allows it.
    function automatic alu_ctrl_t alu_from_f3(input logic [2:0] f3, input logic sub);
        alu_ctrl_t op;
        case (f3)
            F3_ADD:  op = sub ? ALU_SUB : ALU_ADD;
            F3_SLT:  op = ALU_SLT;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idecode_stage_reg_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero, async active-low clear.
module reg_file
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_live;

    assign wr_live = we && (wa != '0);

    // Clear every register on reset; otherwise commit writes, dropping any aimed at x0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wa] <= wd;
        end
    end

    // Port 1: x0 reads zero, a same-cycle write to the address is forwarded.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_live && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    // Port 2: same rules as port 1.
    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_live && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/idecode_stage.sv
// Decode stage: control decode, register read, immediate extension and the
// ID/EX register feeding execute. Register fields are passed through raw.
module idecode_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    output logic [REG_AW-1:0] Rs1D,
    output logic [REG_AW-1:0] Rs2D,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    result_src_t     result_src;
    alu_ctrl_t       alu_ctrl;
    imm_src_t        imm_src;
    logic            imm_used;
    logic [XLEN-1:0] imm_ext;

    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode    = InstrD[6:0];
    assign funct3    = InstrD[14:12];
    assign funct7_b5 = InstrD[30];
    assign Rs1D      = InstrD[19:15];
    assign Rs2D      = InstrD[24:20];

    reg_file u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (Rs1D),
        .ra2   (Rs2D),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Main decoder: unsupported opcode/funct3 combinations leave every control bit at zero.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = RES_ALU;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        imm_used   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = RES_MEM;
                    imm_src    = IMM_I;
                    imm_used   = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_SW) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = IMM_S;
                    imm_used  = 1'b1;
                end
            end
            OP_RTYPE: begin
                if (alu_f3_ok(funct3)) begin
                    reg_write = 1'b1;
                    alu_ctrl  = alu_from_f3(funct3, funct7_b5);
                end
            end
            OP_ITYPE: begin
                if (alu_f3_ok(funct3)) begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_ctrl  = alu_from_f3(funct3, 1'b0);
                    imm_src   = IMM_I;
                    imm_used  = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    branch   = 1'b1;
                    alu_ctrl = ALU_SUB;
                    imm_src  = IMM_B;
                    imm_used = 1'b1;
                end
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
                imm_used   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sign-extend the immediate for the decoded format; zero when no immediate applies.
    always_comb begin
        imm_ext = '0;
        if (imm_used) begin
            case (imm_src)
                IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
                IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                IMM_B:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
                IMM_J:   imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
                default: imm_ext = '0;
            endcase
        end
    end

    // Gather everything execute needs into one record.
    always_comb begin
        idex_d            = '0;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.pc         = PCD;
        idex_d.pc_plus4   = PCPlus4D;
        idex_d.imm_ext    = imm_ext;
        idex_d.rs1        = Rs1D;
        idex_d.rs2        = Rs2D;
        idex_d.rd         = InstrD[11:7];
        idex_d.reg_write  = reg_write;
        idex_d.mem_write  = mem_write;
        idex_d.jump       = jump;
        idex_d.branch     = branch;
        idex_d.alu_src    = alu_src;
        idex_d.result_src = result_src;
        idex_d.alu_ctrl   = alu_ctrl;
    end

    // ID/EX register: reset or a flush loads a bubble, otherwise capture the decoded instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign ImmExtE     = idex_q.imm_ext;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;

endmodule

// File: tb/tb_idecode_stage.sv
// Scoreboard bench for idecode_stage: directed instructions push hand-computed
// ID/EX contents into a queue, a negedge monitor pops and compares.
module tb_idecode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  ctl;
        bit          chkImm;
    } exp_t;

    exp_t scoreboard[$];
    int   checks   = 0;
    int   failures = 0;
    exp_t e;

    idecode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .FlushE      (FlushE),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ImmExtE     (ImmExtE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ctl packs {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    function automatic exp_t makeExp(input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic [31:0] pc, input logic [31:0] imm,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [9:0] ctl);
        exp_t x;
        x.rd1    = rd1;
        x.rd2    = rd2;
        x.pc     = pc;
        x.pc4    = pc + 32'd4;
        x.imm    = imm;
        x.rs1    = rs1;
        x.rs2    = rs2;
        x.rd     = rd;
        x.ctl    = ctl;
        x.chkImm = 1'b1;
        return x;
    endfunction

    function automatic exp_t zeroExp();
        exp_t x;
        x        = makeExp('0, '0, '0, '0, '0, '0, '0, '0);
        x.pc4    = '0;
        return x;
    endfunction

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic flush, input logic wbEn,
                                 input logic [4:0] wbRd, input logic [31:0] wbData,
                                 input exp_t x);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        FlushE    = flush;
        RegWriteW = wbEn;
        RdW       = wbRd;
        ResultW   = wbData;
        #1;
        checkOutput("Rs1D", {27'b0, Rs1D}, {27'b0, instr[19:15]});
        checkOutput("Rs2D", {27'b0, Rs2D}, {27'b0, instr[24:20]});
        @(posedge clk);
        scoreboard.push_back(x);
        #1;
    endtask

    // Monitor: every falling edge with a pending expectation compares the whole ID/EX output set.
    always @(negedge clk) begin
        exp_t m;
        if (scoreboard.size() > 0) begin
            m = scoreboard.pop_front();
            checkOutput("RD1E", RD1E, m.rd1);
            checkOutput("RD2E", RD2E, m.rd2);
            checkOutput("PCE", PCE, m.pc);
            checkOutput("PCPlus4E", PCPlus4E, m.pc4);
            if (m.chkImm) checkOutput("ImmExtE", ImmExtE, m.imm);
            checkOutput("Rs1E", {27'b0, Rs1E}, {27'b0, m.rs1});
            checkOutput("Rs2E", {27'b0, Rs2E}, {27'b0, m.rs2});
            checkOutput("RdE", {27'b0, RdE}, {27'b0, m.rd});
            checkOutput("RegWriteE", {31'b0, RegWriteE}, {31'b0, m.ctl[9]});
            checkOutput("MemWriteE", {31'b0, MemWriteE}, {31'b0, m.ctl[8]});
            checkOutput("JumpE", {31'b0, JumpE}, {31'b0, m.ctl[7]});
            checkOutput("BranchE", {31'b0, BranchE}, {31'b0, m.ctl[6]});
            checkOutput("ALUSrcE", {31'b0, ALUSrcE}, {31'b0, m.ctl[5]});
            checkOutput("ResultSrcE", {30'b0, ResultSrcE}, {30'b0, m.ctl[4:3]});
            checkOutput("ALUControlE", {29'b0, ALUControlE}, {29'b0, m.ctl[2:0]});
        end
    end

    initial begin
        reset     = 1'b0;
        InstrD    = '0;
        PCD       = '0;
        PCPlus4D  = '0;
        FlushE    = 1'b0;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        #1;
        scoreboard.push_back(zeroExp());
        @(negedge clk);
        #1;
        reset = 1'b1;

        // add x6,x5,x5 while x5 is being written: bypass
        e = makeExp(32'hDEADBEEF, 32'hDEADBEEF, 32'h100, '0, 5'd5, 5'd5, 5'd6, 10'b1_0_0_0_0_00_000);
        e.chkImm = 1'b0;
        applyStimulus(32'h00528333, 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, e);
        // same read from the stored register
        e.pc = 32'h104; e.pc4 = 32'h108;
        applyStimulus(32'h00528333, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // add x7,x0,x0 with a write to x0 in flight, then again afterwards
        e = makeExp('0, '0, 32'h108, '0, 5'd0, 5'd0, 5'd7, 10'b1_0_0_0_0_00_000);
        e.chkImm = 1'b0;
        applyStimulus(32'h000003B3, 32'h108, 1'b0, 1'b1, 5'd0, 32'h7, e);
        e.pc = 32'h10C; e.pc4 = 32'h110;
        applyStimulus(32'h000003B3, 32'h10C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // sub x8,x5,x0
        e = makeExp(32'hDEADBEEF, '0, 32'h110, '0, 5'd5, 5'd0, 5'd8, 10'b1_0_0_0_0_00_001);
        e.chkImm = 1'b0;
        applyStimulus(32'h40028433, 32'h110, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // addi x9,x5,-1: bit30 set but never sub
        e = makeExp(32'hDEADBEEF, '0, 32'h114, 32'hFFFFFFFF, 5'd5, 5'd31, 5'd9, 10'b1_0_0_0_1_00_000);
        applyStimulus(32'hFFF28493, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // lw x1,-4(x2)
        e = makeExp('0, '0, 32'h118, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd1, 10'b1_0_0_0_1_01_000);
        applyStimulus(32'hFFC12083, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // sw x5,8(x2)
        e = makeExp('0, 32'hDEADBEEF, 32'h11C, 32'h8, 5'd2, 5'd5, 5'd8, 10'b0_1_0_0_1_00_000);
        applyStimulus(32'h00512423, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // beq x0,x0,-8
        e = makeExp('0, '0, 32'h120, 32'hFFFFFFF8, 5'd0, 5'd0, 5'd25, 10'b0_0_0_1_0_00_001);
        applyStimulus(32'hFE000CE3, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // and x10,x5,x5 / or x11,x5,x5
        e = makeExp(32'hDEADBEEF, 32'hDEADBEEF, 32'h124, '0, 5'd5, 5'd5, 5'd10, 10'b1_0_0_0_0_00_010);
        e.chkImm = 1'b0;
        applyStimulus(32'h0052F533, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0, e);
        e = makeExp(32'hDEADBEEF, 32'hDEADBEEF, 32'h128, '0, 5'd5, 5'd5, 5'd11, 10'b1_0_0_0_0_00_011);
        e.chkImm = 1'b0;
        applyStimulus(32'h0052E5B3, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // slti x12,x5,5
        e = makeExp(32'hDEADBEEF, 32'hDEADBEEF, 32'h12C, 32'h5, 5'd5, 5'd5, 5'd12, 10'b1_0_0_0_1_00_101);
        applyStimulus(32'h0052A613, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // jal x1,16 flushed while x16 is written, then unflushed reading x16
        applyStimulus(32'h010000EF, 32'h200, 1'b1, 1'b1, 5'd16, 32'h1234, zeroExp());
        e = makeExp('0, 32'h1234, 32'h200, 32'h10, 5'd0, 5'd16, 5'd1, 10'b1_0_1_0_0_10_000);
        applyStimulus(32'h010000EF, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0, e);
        // illegal opcode, lb (unsupported funct3), sll (unsupported R funct3)
        e = makeExp('0, '0, 32'h204, '0, 5'd0, 5'd0, 5'd0, 10'b0);
        applyStimulus(32'h0000007F, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0, e);
        e = makeExp('0, '0, 32'h208, '0, 5'd2, 5'd28, 5'd1, 10'b0);
        applyStimulus(32'hFFC10083, 32'h208, 1'b0, 1'b0, 5'd0, 32'h0, e);
        e = makeExp(32'hDEADBEEF, 32'hDEADBEEF, 32'h20C, '0, 5'd5, 5'd5, 5'd6, 10'b0);
        applyStimulus(32'h00529333, 32'h20C, 1'b0, 1'b0, 5'd0, 32'h0, e);

        // mid-run reset: outputs clear immediately and stay clear across an edge
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_RD1E", RD1E, 32'h0);
        checkOutput("async_RegWriteE", {31'b0, RegWriteE}, 32'h0);
        scoreboard.push_back(zeroExp());
        @(negedge clk);
        #1;
        reset = 1'b1;

        // register file was cleared: x5 and x16 read zero
        e = makeExp('0, '0, 32'h300, '0, 5'd5, 5'd5, 5'd6, 10'b1_0_0_0_0_00_000);
        e.chkImm = 1'b0;
        applyStimulus(32'h00528333, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, e);
        e = makeExp('0, '0, 32'h304, 32'h10, 5'd0, 5'd16, 5'd1, 10'b1_0_1_0_0_10_000);
        applyStimulus(32'h010000EF, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, e);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", scoreboard.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
